// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front end: row_feeder default sizes and the
// frame-sequencing state encoding used by cnn_top and its feeders.
package cnn_pkg;

    localparam int CNN_PIX_W   = 8;
    localparam int CNN_ROW_LEN = 24;
    localparam int CNN_ROWS    = 24;
    localparam int CNN_ROW_GAP = 1000;

    typedef enum logic {
        STREAM      = 1'b0,
        WAIT_RESULT = 1'b1
    } frame_state_t;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/row_feeder.sv
// Packs a pixel stream into rows and hands each row to the classifier at most
// once per ROW_GAP cycles, pausing at frame end until the classifier reports.
module row_feeder
    import cnn_pkg::*;
#(
    parameter int PIX_W   = CNN_PIX_W,
    parameter int ROW_LEN = CNN_ROW_LEN,
    parameter int ROWS    = CNN_ROWS,
    parameter int ROW_GAP = CNN_ROW_GAP
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIX_W-1:0]           pix_i,
    input  logic                       pix_valid_i,
    output logic                       pix_ready_o,
    output logic [ROW_LEN*PIX_W-1:0]   row_data_o,
    output logic                       row_valid_o,
    output logic [cnt_width(ROWS)-1:0] row_idx_o,
    input  logic                       result_valid_i,
    output logic                       frame_done_o
);

    localparam int IDX_W = cnt_width(ROWS);
    localparam int CNT_W = cnt_width(ROW_LEN + 1);
    localparam int GAP_W = cnt_width(ROW_GAP);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ROW_LEN);
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ROW_GAP - 1);

    frame_state_t               state;
    frame_state_t               state_next;
    logic                       frame_done_next;
    logic [CNT_W-1:0]           cnt;
    logic [GAP_W-1:0]           gap_cnt;
    logic [IDX_W-1:0]           row_num;
    logic [ROW_LEN*PIX_W-1:0]   fill;
    logic                       row_full;
    logic                       pix_take;
    logic                       emit;

    // Ready depends only on registered state, so there is no valid->ready path.
    assign row_full    = (cnt == CNT_FULL);
    assign pix_ready_o = !row_full;
    assign pix_take    = pix_valid_i && pix_ready_o;
    assign emit        = row_full && (gap_cnt == '0) && (state == STREAM);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STREAM;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    always_comb begin
        state_next      = state;
        frame_done_next = 1'b0;
        case (state)
            STREAM: begin
                if (emit && (row_num == LAST_ROW)) begin
                    state_next = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                if (result_valid_i) begin
                    state_next      = STREAM;
                    frame_done_next = 1'b1;
                end
            end
            default: state_next = STREAM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            gap_cnt      <= '0;
            row_num      <= '0;
            row_data_o   <= '0;
            row_idx_o    <= '0;
            row_valid_o  <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            row_valid_o  <= emit;
            frame_done_o <= frame_done_next;

            if (emit) begin
                row_data_o <= fill;
                row_idx_o  <= row_num;
                cnt        <= '0;
                gap_cnt    <= GAP_LOAD;
            end else begin
                if (pix_take) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - GAP_W'(1);
                end
            end

            // The row number parks on the last row until the result arrives.
            if (frame_done_next) begin
                row_num <= '0;
            end else if (emit && (row_num != LAST_ROW)) begin
                row_num <= row_num + IDX_W'(1);
            end
        end
    end

    // NOTE: the fill buffer is not reset; every byte is rewritten before a row
    // can be emitted, so a reset would have no observable effect.
    always_ff @(posedge clk) begin
        if (pix_take) begin
            fill[int'(cnt)*PIX_W +: PIX_W] <= pix_i;
        end
    end

endmodule

// File: tb/tb_row_feeder.sv
// Self-checking bench for row_feeder: rows and their timing are predicted from
// the log of accepted pixels and compared with what the monitor observes.
module tb_row_feeder;
    import cnn_pkg::*;

    localparam int PIX_W    = CNN_PIX_W;
    localparam int ROW_LEN  = CNN_ROW_LEN;
    localparam int ROWS     = CNN_ROWS;
    localparam int ROW_GAP  = CNN_ROW_GAP;
    localparam int ROW_BITS = PIX_W * ROW_LEN;
    localparam int IDX_W    = cnt_width(ROWS);

    typedef struct {
        int                  at;
        logic [ROW_BITS-1:0] data;
        logic [IDX_W-1:0]    idx;
    } emit_t;

    logic                clk;
    logic                reset;
    logic [PIX_W-1:0]    pix_i;
    logic                pix_valid_i;
    logic                pix_ready_o;
    logic [ROW_BITS-1:0] row_data_o;
    logic                row_valid_o;
    logic [IDX_W-1:0]    row_idx_o;
    logic                result_valid_i;
    logic                frame_done_o;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int hold_changes = 0;
    int last_drive_edge = 0;

    logic [PIX_W-1:0] sent_q[$];
    int               acc_q[$];
    emit_t            emits_q[$];
    int               done_q[$];

    logic [ROW_BITS-1:0] prev_data;
    logic [IDX_W-1:0]    prev_idx;

    row_feeder #(
        .PIX_W(PIX_W), .ROW_LEN(ROW_LEN), .ROWS(ROWS), .ROW_GAP(ROW_GAP)
    ) dut (
        .clk(clk), .reset(reset), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
        .pix_ready_o(pix_ready_o), .row_data_o(row_data_o), .row_valid_o(row_valid_o),
        .row_idx_o(row_idx_o), .result_valid_i(result_valid_i), .frame_done_o(frame_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: numbers rising edges and logs strobes seen just after each edge.
    always @(posedge clk) begin
        logic rst_at_edge;
        rst_at_edge = reset;
        cyc++;
        #1;
        if (row_valid_o === 1'b1) begin
            emits_q.push_back('{cyc, row_data_o, row_idx_o});
        end else if (!rst_at_edge && (row_data_o !== prev_data || row_idx_o !== prev_idx)) begin
            hold_changes++;
        end
        if (frame_done_o === 1'b1) done_q.push_back(cyc);
        prev_data = row_data_o;
        prev_idx  = row_idx_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference row n: the n-th group of ROW_LEN accepted pixels, pixel 0 in the LSBs.
    function automatic logic [ROW_BITS-1:0] exp_row(input int n);
        logic [ROW_BITS-1:0] r;
        r = '0;
        for (int k = 0; k < ROW_LEN; k++) r[k*PIX_W +: PIX_W] = sent_q[n*ROW_LEN + k];
        return r;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic drive(input logic v, input logic [PIX_W-1:0] d, input logic r, output logic acc);
        @(negedge clk);
        pix_valid_i = v;
        pix_i = d;
        result_valid_i = r;
        last_drive_edge = cyc + 1;
        #1;
        acc = v && (pix_ready_o === 1'b1);
        if (acc) begin
            sent_q.push_back(d);
            acc_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) drive(1'b0, '0, 1'b0, acc);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        pix_valid_i = 1'b0;
        pix_i = '0;
        result_valid_i = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        sent_q.delete();
        acc_q.delete();
        emits_q.delete();
        done_q.delete();
        hold_changes = 0;
    endtask

    // Offer pixels at the given duty until n are accepted; base >= 0 gives base, base+1, ...
    task automatic feed(input int n, input int duty, input int base, input int budget, output bit ok);
        int got;
        int spent;
        logic acc;
        logic v;
        logic [PIX_W-1:0] d;
        got = 0;
        spent = 0;
        while (got < n && spent < budget) begin
            v = ($urandom_range(99) < duty);
            d = (base >= 0) ? PIX_W'(base + got) : PIX_W'($urandom);
            drive(v, d, 1'b0, acc);
            if (acc) got++;
            spent++;
        end
        drive(1'b0, '0, 1'b0, acc);
        ok = (got == n);
    endtask

    task automatic wait_emits(input int k, input int budget);
        int spent;
        spent = 0;
        while (emits_q.size() < k && spent < budget) begin
            idle(1);
            spent++;
        end
    endtask

    task automatic test_reset();
        bit ok;
        do_reset(3);
        feed(ROW_LEN + 6, 100, -1, 200, ok);
        idle(3);
        do_reset(2);
        tests++; if (row_valid_o !== 1'b0) begin fails++; $display("FAIL reset_row_valid: got %b expected 0", row_valid_o); end
        tests++; if (frame_done_o !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", frame_done_o); end
        tests++; if (row_data_o !== '0) begin fails++; $display("FAIL reset_row_data: got %h expected 0", row_data_o); end
        tests++; if (row_idx_o !== '0) begin fails++; $display("FAIL reset_row_idx: got %0d expected 0", row_idx_o); end
        tests++; if (pix_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", pix_ready_o); end
    endtask

    task automatic test_single_row();
        bit ok;
        emit_t e;
        do_reset(2);
        feed(ROW_LEN, 100, 10, 100, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL single_feed: got %0d accepted expected %0d", sent_q.size(), ROW_LEN); end
        wait_emits(1, 20);
        idle(5);
        tests++; if (emits_q.size() !== 1) begin fails++; $display("FAIL single_count: got %0d expected 1", emits_q.size()); end
        if (emits_q.size() >= 1) begin
            e = emits_q[0];
            tests++; if (e.data[PIX_W-1:0] !== PIX_W'(10)) begin fails++; $display("FAIL single_byte0: got %0d expected 10", e.data[PIX_W-1:0]); end
            tests++; if (e.data[(ROW_LEN-1)*PIX_W +: PIX_W] !== PIX_W'(33)) begin fails++; $display("FAIL single_byte23: got %0d expected 33", e.data[(ROW_LEN-1)*PIX_W +: PIX_W]); end
            tests++; if (e.data !== exp_row(0)) begin fails++; $display("FAIL single_data: got %h expected %h", e.data, exp_row(0)); end
            tests++; if (e.idx !== '0) begin fails++; $display("FAIL single_idx: got %0d expected 0", e.idx); end
            tests++; if (e.at !== acc_q[ROW_LEN-1] + 1) begin fails++; $display("FAIL single_latency: got edge %0d expected %0d", e.at, acc_q[ROW_LEN-1] + 1); end
        end
        idle(20);
        tests++; if (row_data_o !== exp_row(0)) begin fails++; $display("FAIL single_hold_data: got %h expected %h", row_data_o, exp_row(0)); end
        tests++; if (hold_changes !== 0) begin fails++; $display("FAIL single_hold_changes: got %0d expected 0", hold_changes); end
        tests++; if (row_valid_o !== 1'b0) begin fails++; $display("FAIL single_strobe_width: got %b expected 0", row_valid_o); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int spent;
        int ready_high;
        do_reset(2);
        feed(2 * ROW_LEN, 100, -1, 200, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL b2b_feed: got %0d accepted expected %0d", sent_q.size(), 2 * ROW_LEN); end
        spent = 0;
        ready_high = (pix_ready_o === 1'b1) ? 1 : 0;
        while (spent < ROW_GAP + 100) begin
            idle(1);
            spent++;
            if (emits_q.size() >= 2) break;
            if (pix_ready_o !== 1'b0) ready_high++;
        end
        tests++; if (emits_q.size() !== 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", emits_q.size()); end
        tests++; if (ready_high !== 0) begin fails++; $display("FAIL b2b_ready_low: got %0d ready cycles expected 0", ready_high); end
        tests++; if (pix_ready_o !== 1'b1) begin fails++; $display("FAIL b2b_ready_after: got %b expected 1", pix_ready_o); end
        if (emits_q.size() >= 2) begin
            tests++; if (emits_q[0].at !== acc_q[ROW_LEN-1] + 1) begin fails++; $display("FAIL b2b_first_edge: got %0d expected %0d", emits_q[0].at, acc_q[ROW_LEN-1] + 1); end
            tests++; if (emits_q[1].at - emits_q[0].at !== ROW_GAP) begin fails++; $display("FAIL b2b_spacing: got %0d expected %0d", emits_q[1].at - emits_q[0].at, ROW_GAP); end
            tests++; if (emits_q[1].data !== exp_row(1)) begin fails++; $display("FAIL b2b_data: got %h expected %h", emits_q[1].data, exp_row(1)); end
            tests++; if (emits_q[1].idx !== IDX_W'(1)) begin fails++; $display("FAIL b2b_idx: got %0d expected 1", emits_q[1].idx); end
        end
    endtask

    // Full frame with 50% valid duty and a stray result pulse while streaming,
    // then the frame-end handshake and the first row of the next frame.
    task automatic test_frame();
        int got;
        int spent;
        int prev;
        int want;
        int r_edge;
        logic acc;
        do_reset(2);
        got = 0;
        spent = 0;
        while (got < (ROWS + 1) * ROW_LEN && spent < 40000) begin
            drive($urandom_range(1) == 1, PIX_W'($urandom), spent == 300, acc);
            if (acc) got++;
            spent++;
        end
        idle(ROW_GAP + 200);
        tests++; if (got !== (ROWS + 1) * ROW_LEN) begin fails++; $display("FAIL frame_feed: got %0d accepted expected %0d", got, (ROWS + 1) * ROW_LEN); end
        tests++; if (emits_q.size() !== ROWS) begin fails++; $display("FAIL frame_count: got %0d expected %0d", emits_q.size(), ROWS); end
        tests++; if (done_q.size() !== 0) begin fails++; $display("FAIL frame_stray_result: got %0d done pulses expected 0", done_q.size()); end
        tests++; if (pix_ready_o !== 1'b0) begin fails++; $display("FAIL frame_staged_ready: got %b expected 0", pix_ready_o); end
        prev = -ROW_GAP;
        for (int n = 0; n < ROWS && n < emits_q.size(); n++) begin
            want = max2(acc_q[n*ROW_LEN + ROW_LEN - 1] + 1, prev + ROW_GAP);
            tests++; if (emits_q[n].idx !== IDX_W'(n)) begin fails++; $display("FAIL frame_idx row %0d: got %0d expected %0d", n, emits_q[n].idx, n); end
            tests++; if (emits_q[n].data !== exp_row(n)) begin fails++; $display("FAIL frame_data row %0d: got %h expected %h", n, emits_q[n].data, exp_row(n)); end
            tests++; if (emits_q[n].at !== want) begin fails++; $display("FAIL frame_timing row %0d: got edge %0d expected %0d", n, emits_q[n].at, want); end
            prev = emits_q[n].at;
        end
        drive(1'b0, '0, 1'b1, acc);
        r_edge = last_drive_edge;
        idle(10);
        tests++; if (done_q.size() !== 1) begin fails++; $display("FAIL frame_done_count: got %0d expected 1", done_q.size()); end
        if (done_q.size() >= 1) begin
            tests++; if (done_q[0] !== r_edge) begin fails++; $display("FAIL frame_done_edge: got %0d expected %0d", done_q[0], r_edge); end
        end
        tests++; if (emits_q.size() !== ROWS + 1) begin fails++; $display("FAIL frame_next_count: got %0d expected %0d", emits_q.size(), ROWS + 1); end
        if (emits_q.size() >= ROWS + 1) begin
            tests++; if (emits_q[ROWS].idx !== '0) begin fails++; $display("FAIL frame_next_idx: got %0d expected 0", emits_q[ROWS].idx); end
            tests++; if (emits_q[ROWS].data !== exp_row(ROWS)) begin fails++; $display("FAIL frame_next_data: got %h expected %h", emits_q[ROWS].data, exp_row(ROWS)); end
            tests++; if (emits_q[ROWS].at !== r_edge + 1) begin fails++; $display("FAIL frame_next_edge: got %0d expected %0d", emits_q[ROWS].at, r_edge + 1); end
        end
        tests++; if (pix_ready_o !== 1'b1) begin fails++; $display("FAIL frame_next_ready: got %b expected 1", pix_ready_o); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset(2);
        feed(5 * ROW_LEN + 13, 100, -1, 6000, ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL mid_feed: got %0d accepted expected %0d", sent_q.size(), 5 * ROW_LEN + 13); end
        tests++; if (emits_q.size() !== 5) begin fails++; $display("FAIL mid_pre_count: got %0d expected 5", emits_q.size()); end
        do_reset(2);
        tests++; if (row_data_o !== '0) begin fails++; $display("FAIL mid_reset_data: got %h expected 0", row_data_o); end
        tests++; if (row_idx_o !== '0) begin fails++; $display("FAIL mid_reset_idx: got %0d expected 0", row_idx_o); end
        tests++; if (pix_ready_o !== 1'b1) begin fails++; $display("FAIL mid_reset_ready: got %b expected 1", pix_ready_o); end
        idle(3);
        tests++; if (emits_q.size() !== 0) begin fails++; $display("FAIL mid_no_emit: got %0d pulses expected 0", emits_q.size()); end
        feed(ROW_LEN, 100, -1, 100, ok);
        idle(5);
        tests++; if (emits_q.size() !== 1) begin fails++; $display("FAIL mid_new_count: got %0d expected 1", emits_q.size()); end
        if (emits_q.size() >= 1) begin
            tests++; if (emits_q[0].idx !== '0) begin fails++; $display("FAIL mid_new_idx: got %0d expected 0", emits_q[0].idx); end
            tests++; if (emits_q[0].data !== exp_row(0)) begin fails++; $display("FAIL mid_new_data: got %h expected %h", emits_q[0].data, exp_row(0)); end
            tests++; if (emits_q[0].at !== acc_q[ROW_LEN-1] + 1) begin fails++; $display("FAIL mid_new_edge: got %0d expected %0d", emits_q[0].at, acc_q[ROW_LEN-1] + 1); end
        end
    endtask

    initial begin
        reset = 1'b1;
        pix_valid_i = 1'b0;
        pix_i = '0;
        result_valid_i = 1'b0;
        test_reset();
        test_single_row();
        test_back_to_back();
        test_frame();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/row_feeder.md
ROW_FEEDER -- requirements
Module: row_feeder

Interface
REQ-001 Parameter PIX_W, default 8, bits per pixel.
REQ-002 Parameter ROW_LEN, default 24, pixels per row.
REQ-003 Parameter ROWS, default 24, rows per frame.
REQ-004 Parameter ROW_GAP, default 1000, minimum cycles between successive row_valid_o pulses.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pix_i  input  PIX_W  incoming pixel.
REQ-008 pix_valid_i  input  1  pix_i valid.
REQ-009 pix_ready_o  output  1  block can accept a pixel.
REQ-010 row_data_o  output  ROW_LEN*PIX_W  packed row; drives cnn_top input_data.
REQ-011 row_valid_o  output  1  one-cycle row strobe; drives cnn_top buffer_1_valid_i.
REQ-012 row_idx_o  output  clog2(ROWS)  index of the row on row_data_o.
REQ-013 result_valid_i  input  1  classifier result strobe; driven by cnn_top dense_valid.
REQ-014 frame_done_o  output  1  one-cycle strobe, frame fully classified.

Function
REQ-015 Pixel transfer SHALL occur on an edge where pix_valid_i and pix_ready_o are both 1.
REQ-016 Fill counter cnt (0..ROW_LEN) SHALL increment per transfer; pixel k of a row is written to fill bits [k*PIX_W +: PIX_W], so pixel 0 is the LSB byte.
REQ-017 pix_ready_o SHALL equal (cnt != ROW_LEN); it is combinational from registered state only, with no path from pix_valid_i.
REQ-018 Emit condition: cnt == ROW_LEN, gap counter == 0, and frame state is STREAM.
REQ-019 On an edge meeting the emit condition, the block SHALL load row_data_o from fill, set row_idx_o to the current row number, pulse row_valid_o for exactly one cycle, clear cnt to 0, and load the gap counter with ROW_GAP-1.
REQ-020 Latency: row_valid_o SHALL be high in the cycle following the edge after the one that captured the last pixel of a row, provided the emit condition holds.
REQ-021 The gap counter SHALL decrement once per cycle to 0 and saturate there; consecutive row_valid_o pulses are therefore at least ROW_GAP cycles apart.
REQ-022 row_data_o and row_idx_o SHALL hold their values between pulses.
REQ-023 While cnt == ROW_LEN and emit is blocked, the full row SHALL be held, pix_ready_o stays 0, and no pixel is lost or overwritten.
REQ-024 Frame FSM states SHALL be STREAM and WAIT_RESULT; the reset state is STREAM.
REQ-025 STREAM -> WAIT_RESULT SHALL occur on the emit of row ROWS-1.
REQ-026 WAIT_RESULT -> STREAM SHALL occur on result_valid_i == 1; on the same edge, frame_done_o pulses for one cycle and the row number wraps to 0.
REQ-027 In WAIT_RESULT, filling SHALL continue, so the first row of the next frame may be staged but is not emitted.
REQ-028 result_valid_i in STREAM SHALL be ignored.
REQ-029 A simultaneous pixel transfer and emit cannot occur (ready is 0 when cnt == ROW_LEN); no special case is required.
REQ-030 The row number SHALL be a counter from 0 to ROWS-1; it increments on each emit and is never driven beyond ROWS-1.

Reset
REQ-031 On reset, cnt, gap counter, row number, row_data_o, row_idx_o, row_valid_o and frame_done_o SHALL be 0, and the FSM SHALL be in STREAM.
REQ-032 pix_ready_o SHALL read 1 in the first cycle after reset is released.
REQ-033 Reset asserted mid-row or mid-frame SHALL discard the partial row and frame; no row_valid_o pulse occurs during or immediately after reset.

Structure
REQ-034 Defaults for PIX_W, ROW_LEN, ROWS and ROW_GAP, plus the FSM state encoding, SHALL live in the shared cnn package used by cnn_top.
REQ-035 The block SHALL be a single module with no sub-modules; the gap timer is inline.

Verification
REQ-036 Feed 24 pixels 10..33 back-to-back after reset -> one row_valid_o pulse; row_data_o byte0 = 10, byte23 = 33; row_idx_o = 0.
REQ-037 Feed 48 pixels continuously -> second pulse exactly ROW_GAP (1000) cycles after the first; pix_ready_o low from the 48th acceptance until the second emit.
REQ-038 Stream 24 rows, then hold result_valid_i low -> 24 pulses with row_idx_o 0..23; a 25th staged row is not emitted; pulse result_valid_i -> frame_done_o one cycle, next row emitted with row_idx_o = 0.
REQ-039 Pulse result_valid_i during STREAM -> no frame_done_o, no FSM change.
REQ-040 Assert reset after 13 pixels of row 5 -> all outputs 0; new 24 pixels produce row_idx_o = 0 containing only the new data.
REQ-041 Random pix_valid_i gaps (50% duty) over a full frame -> packed data matches the reference model; no pixel is dropped or duplicated.
